ir_frame_ctrl: RTL

Sequencer for the remote-control receive path. Measures mark/space widths on the demodulated IR line, decodes an NEC-style 32-bit frame (address, ~address, command, ~command, LSB first), and drives the per-bit strobes (`ordem`, `b`, `enable`) consumed by the bit-to-byte assembler. It also checks the complement bytes and publishes the validated address/command pair. Sits between the IR receiver pin and the key-decode logic.

---
 rtl/ir_frame_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ir_frame_ctrl.sv
// rtl/ir_frame_ctrl.sv - NEC-style IR frame sequencer driving per-bit assembler strobes
// Define IR_REPEAT_EN to decode the repeat code; otherwise it is rejected as an error.
module ir_frame_ctrl #(
    parameter int UNIT_CYC = 28125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ir_in,
    output logic [7:0] ordem,
    output logic       b,
    output logic       enable,
    output logic [1:0] byte_idx,
    output logic [7:0] addr_o,
    output logic [7:0] cmd_o,
    output logic       frame_valid,
    output logic       repeat_o,
    output logic       err_o,
    output logic       busy
);
    localparam int HALF = (UNIT_CYC / 2 < 1) ? 1 : UNIT_CYC / 2;
    localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] HALF_M1 = PW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
    } state_t;

    logic          r_sync1, r_sync2, r_ir_d;
    logic [PW-1:0] r_presc;
    logic [5:0]    r_width;
    state_t        r_state;
    logic [4:0]    r_k;
    logic [31:0]   r_frame;
    logic          r_is_rep;
    logic [7:0]    r_ordem, r_addr, r_cmd;
    logic [1:0]    r_byte_idx;
    logic          r_b, r_enable, r_fv, r_rep, r_err;

    logic w_rise, w_fall, w_edge, w_tmo, w_edge_ok, w_bad;
    logic w_lead_mark, w_lead_space, w_short, w_long, w_chk_ok;

    assign w_fall = r_ir_d & ~r_sync2;
    assign w_rise = ~r_ir_d & r_sync2;
    assign w_edge = w_fall | w_rise;
    assign w_tmo  = (r_width >= 6'd41);

    assign w_lead_mark  = (r_width >= 6'd24) && (r_width <= 6'd40);
    assign w_lead_space = (r_width >= 6'd12) && (r_width <= 6'd20);
    assign w_short      = (r_width >= 6'd1)  && (r_width <= 6'd3);
    assign w_long       = (r_width >= 6'd4)  && (r_width <= 6'd8);
    assign w_chk_ok     = (r_frame[15:8] == ~r_frame[7:0]) &&
                          (r_frame[31:24] == ~r_frame[23:16]);

`ifdef IR_REPEAT_EN
    logic w_rep_space;
    assign w_rep_space = (r_width >= 6'd6) && (r_width <= 6'd10);
`endif

    // Half-unit width measurement, restarted on every synchronized edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_ir_d  <= 1'b1;
            r_presc <= '0;
            r_width <= '0;
        end else begin
            r_sync1 <= ir_in;
            r_sync2 <= r_sync1;
            r_ir_d  <= r_sync2;
            if (w_edge) begin
                r_presc <= '0;
                r_width <= '0;
            end else if (r_presc == HALF_M1) begin
                r_presc <= '0;
                if (r_width != 6'd63)
                    r_width <= r_width + 6'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_comb begin
        w_edge_ok = 1'b0;
        case (r_state)
            LEAD_MARK:  w_edge_ok = w_lead_mark;
            LEAD_SPACE: begin
                w_edge_ok = w_lead_space;
`ifdef IR_REPEAT_EN
                if (w_rep_space)
                    w_edge_ok = 1'b1;
`endif
            end
            BIT_MARK:   w_edge_ok = w_short;
            BIT_SPACE:  w_edge_ok = w_short | w_long;
            STOP_MARK:  w_edge_ok = w_short && (r_is_rep || w_chk_ok);
            default:    w_edge_ok = 1'b0;
        endcase
    end

    // An edge always takes priority over a coincident timeout.
    assign w_bad = (r_state != IDLE) && (w_edge ? !w_edge_ok : w_tmo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_frame    <= '0;
            r_is_rep   <= 1'b0;
            r_ordem    <= '0;
            r_b        <= 1'b0;
            r_byte_idx <= '0;
            r_addr     <= '0;
            r_cmd      <= '0;
            r_enable   <= 1'b0;
            r_fv       <= 1'b0;
            r_rep      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            r_fv     <= 1'b0;
            r_rep    <= 1'b0;
            r_err    <= 1'b0;
            if (w_bad) begin
                r_err   <= 1'b1;
                r_state <= IDLE;
            end else if (w_edge) begin
                case (r_state)
                    IDLE: if (w_fall) r_state <= LEAD_MARK;
                    LEAD_MARK: r_state <= LEAD_SPACE;
                    LEAD_SPACE: begin
                        r_k      <= '0;
                        r_is_rep <= 1'b0;
                        r_state  <= BIT_MARK;
`ifdef IR_REPEAT_EN
                        if (w_rep_space) begin
                            r_is_rep <= 1'b1;
                            r_state  <= STOP_MARK;
                        end
`endif
                    end
                    BIT_MARK: r_state <= BIT_SPACE;
                    BIT_SPACE: begin
                        r_b          <= w_long;
                        r_ordem      <= {5'd0, ~r_k[2:0]};
                        r_byte_idx   <= r_k[4:3];
                        r_enable     <= 1'b1;
                        r_frame[r_k] <= w_long;
                        r_k          <= r_k + 5'd1;
                        r_state      <= (r_k == 5'd31) ? STOP_MARK : BIT_MARK;
                    end
                    STOP_MARK: begin
                        r_state <= IDLE;
                        if (r_is_rep) begin
                            r_rep <= 1'b1;
                        end else begin
                            r_fv   <= 1'b1;
                            r_addr <= r_frame[7:0];
                            r_cmd  <= r_frame[23:16];
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ordem       = r_ordem;
    assign b           = r_b;
    assign enable      = r_enable;
    assign byte_idx    = r_byte_idx;
    assign addr_o      = r_addr;
    assign cmd_o       = r_cmd;
    assign frame_valid = r_fv;
    assign repeat_o    = r_rep;
    assign err_o       = r_err;
    assign busy        = (r_state != IDLE);
endmodule
